// File: rtl/uart_tx_core.sv
// uart_tx_core
//   Streaming UART transmitter. Characters enter through a valid/ready
//   handshake into a small FIFO. A frame FSM serialises each character as
//   start bit, DATA_W data bits (LSB first), an optional parity bit, and
//   STOP_BITS stop bits. Each bit lasts BAUD_DIV clk cycles.
//
// Parameters
//   CLK_FREQ, BAUD  clock and line rate in Hz / bit/s; BAUD_DIV is rounded.
//   DATA_W          data bits per character (5..8).
//   PARITY          0 = none, 1 = odd, 2 = even.
//   STOP_BITS       1 or 2.
//   FIFO_DEPTH      FIFO entries, power of two, >= 2.
//
// Ports
//   clk, rst     clock; asynchronous active-high reset.
//   tx_data      character to send.
//   tx_valid     producer offers tx_data.
//   tx_ready     FIFO not full.
//   uart_tx      registered serial line, idle high.
//   busy         frame on the line or FIFO non-empty.
//   frame_done   one-cycle pulse during the last cycle of the last stop bit.
//   fifo_level   occupied FIFO entries, 0..FIFO_DEPTH.
module uart_tx_core #(
  parameter int CLK_FREQ   = 125_000_000,
  parameter int BAUD       = 115_200,
  parameter int DATA_W     = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              uart_tx,
  output logic              busy,
  output logic              frame_done,
  output logic [LW-1:0]     fifo_level
);

  localparam int BAUD_DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int CW       = $clog2(BAUD_DIV);
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int BW       = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t            state;
  logic [CW-1:0]     baud_cnt;
  logic [BW-1:0]     bit_idx;
  logic              stop_idx;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] shreg;
  logic              par_bit;

  logic fifo_full;
  logic fifo_empty;
  logic wr_en;
  logic pop_en;
  logic baud_wrap;
  logic last_stop;
  logic frame_end;

  assign fifo_full  = (fifo_level == LW'(FIFO_DEPTH));
  assign fifo_empty = (fifo_level == '0);
  assign tx_ready   = !fifo_full;
  assign wr_en      = tx_valid && tx_ready;
  assign head       = mem[rd_ptr];

  assign baud_wrap  = (baud_cnt == CW'(BAUD_DIV - 1));
  assign last_stop  = (stop_idx == 1'(STOP_BITS - 1));
  assign frame_end  = (state == STOP) && baud_wrap && last_stop;

  // A pop happens either from IDLE or at the very end of a frame, so the
  // next start bit follows the last stop bit with no idle gap.
  assign pop_en     = !fifo_empty && ((state == IDLE) || frame_end);

  assign busy       = (state != IDLE) || !fifo_empty;

  // ---- FIFO storage (data only, not reset) ----
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= tx_data;
  end

  // ---- FIFO pointers and level ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + AW'(1);
      if (pop_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop_en})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // ---- Shift register and parity (data only, not reset) ----
  // Parity is captured at pop time over the DATA_W character bits.
  always_ff @(posedge clk) begin
    if (pop_en) begin
      shreg   <= head;
      par_bit <= (PARITY == 2) ? ^head : ~^head;
    end else if (baud_wrap && ((state == START) || (state == DATA))) begin
      shreg <= shreg >> 1;
    end
  end

  // ---- Frame FSM with registered line and frame_done ----
  // uart_tx is loaded with the value of the *next* bit on the edge that ends
  // the current bit, so the line is a clean register output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      uart_tx    <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      if (state == IDLE || baud_wrap) baud_cnt <= '0;
      else                            baud_cnt <= baud_cnt + CW'(1);

      // Registered pulse lands on the final cycle of the last stop bit.
      frame_done <= (state == STOP) && last_stop &&
                    (baud_cnt == CW'(BAUD_DIV - 2));

      case (state)
        IDLE: begin
          uart_tx <= 1'b1;
          if (!fifo_empty) begin
            state   <= START;
            uart_tx <= 1'b0;
            bit_idx <= '0;
          end
        end
        START: begin
          if (baud_wrap) begin
            state   <= DATA;
            uart_tx <= shreg[0];
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (baud_wrap) begin
            if (bit_idx == BW'(DATA_W - 1)) begin
              if (PARITY != 0) begin
                state   <= PAR;
                uart_tx <= par_bit;
              end else begin
                state    <= STOP;
                uart_tx  <= 1'b1;
                stop_idx <= 1'b0;
              end
            end else begin
              bit_idx <= bit_idx + BW'(1);
              uart_tx <= shreg[0];
            end
          end
        end
        PAR: begin
          if (baud_wrap) begin
            state    <= STOP;
            uart_tx  <= 1'b1;
            stop_idx <= 1'b0;
          end
        end
        STOP: begin
          if (baud_wrap) begin
            if (last_stop) begin
              if (!fifo_empty) begin
                state   <= START;
                uart_tx <= 1'b0;
                bit_idx <= '0;
              end else begin
                state   <= IDLE;
                uart_tx <= 1'b1;
              end
            end else begin
              stop_idx <= stop_idx + 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          uart_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Testbench for uart_tx_core: five instances with different build-time
// formats share one clock. A line receiver per instance decodes frames and
// checks them against a queue of accepted characters; directed code checks
// handshake timing, FIFO level behaviour, reset and bit-period length.
module tb_uart_tx_core;

  logic       clk = 1'b0;
  logic       rst0;
  logic       rstc;
  logic       v    [5];
  logic [7:0] d    [5];
  logic       line [5];
  logic       rdy  [5];
  logic       bsy  [5];
  logic       fd   [5];
  logic [2:0] lvl  [5];
  logic       mon_en [5];

  logic [7:0] expq [5][$];

  int vecs = 0;
  int miss = 0;
  int cyc  = 0;
  int maxlvl0 = 0;
  int rdybad0 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (int'(lvl[0]) > maxlvl0) maxlvl0 <= int'(lvl[0]);
    if (rdy[0] !== (lvl[0] != 3'd4)) rdybad0 <= rdybad0 + 1;
  end

  // 8N1, 10 cycles/bit
  uart_tx_core #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_W(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .rst(rst0), .tx_data(d[0]), .tx_valid(v[0]), .tx_ready(rdy[0]),
    .uart_tx(line[0]), .busy(bsy[0]), .frame_done(fd[0]), .fifo_level(lvl[0]));
  // 8E2
  uart_tx_core #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_W(8), .PARITY(2),
                 .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .rst(rstc), .tx_data(d[1]), .tx_valid(v[1]), .tx_ready(rdy[1]),
    .uart_tx(line[1]), .busy(bsy[1]), .frame_done(fd[1]), .fifo_level(lvl[1]));
  // 8O1
  uart_tx_core #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_W(8), .PARITY(1),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
    .clk(clk), .rst(rstc), .tx_data(d[2]), .tx_valid(v[2]), .tx_ready(rdy[2]),
    .uart_tx(line[2]), .busy(bsy[2]), .frame_done(fd[2]), .fifo_level(lvl[2]));
  // 7O1
  uart_tx_core #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_W(7), .PARITY(1),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u3 (
    .clk(clk), .rst(rstc), .tx_data(d[3][6:0]), .tx_valid(v[3]), .tx_ready(rdy[3]),
    .uart_tx(line[3]), .busy(bsy[3]), .frame_done(fd[3]), .fifo_level(lvl[3]));
  // 125 MHz / 115200 -> 1085 cycles/bit
  uart_tx_core #(.CLK_FREQ(125_000_000), .BAUD(115_200), .DATA_W(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u4 (
    .clk(clk), .rst(rstc), .tx_data(d[4]), .tx_valid(v[4]), .tx_ready(rdy[4]),
    .uart_tx(line[4]), .busy(bsy[4]), .frame_done(fd[4]), .fifo_level(lvl[4]));

  task automatic chk(input string nm, input longint act, input longint req);
    vecs++;
    if (act != req) begin
      miss++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  // Called at a negedge. Holds tx_valid until the character is accepted on
  // a rising edge, then returns at the following negedge with tx_valid still
  // high so back-to-back calls keep the handshake continuous.
  task automatic send(input int k, input logic [7:0] b);
    logic ok;
    int   t;
    t = 0;
    v[k] = 1'b1;
    d[k] = b;
    forever begin
      ok = rdy[k];
      @(posedge clk);
      t++;
      if (ok || t > 2000) break;
      @(negedge clk);
    end
    if (ok) expq[k].push_back(b);
    else    chk("send_timeout", 0, 1);
    @(negedge clk);
  endtask

  // Entry: negedge after the accepting edge E0 of an idle, empty instance.
  task automatic launch(input int k);
    v[k] = 1'b0;
    chk("level_after_write", lvl[k], 1);
    chk("line_high_after_write", line[k], 1);
    chk("busy_after_write", bsy[k], 1);
    @(negedge clk);
    chk("line_falls_after_pop", line[k], 0);
    chk("level_after_pop", lvl[k], 0);
  endtask

  // Entry: negedge in the first start-bit cycle. req = edges from the fall
  // to the edge that raises frame_done (last cycle of the frame).
  task automatic frame_len(input int k, input int req);
    int n;
    n = 0;
    while (!fd[k] && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("frame_done_offset", n, req);
    @(negedge clk);
    chk("frame_done_single_cycle", fd[k], 0);
    chk("busy_clears", bsy[k], 0);
    chk("line_idle_after_frame", line[k], 1);
  endtask

  // Line receiver: samples each bit in its centre and compares the whole
  // frame against start/data/parity/stop bits built from the queued byte.
  task automatic monitor(input int k, input int dw, input int par, input int sb,
                         input int div);
    logic [15:0] got;
    logic [15:0] req;
    logic [7:0]  b;
    int          nb;
    int          ones;
    nb = 1 + dw + ((par != 0) ? 1 : 0) + sb;
    forever begin
      @(negedge clk);
      if (line[k] !== 1'b0) continue;
      got = '0;
      repeat (div / 2) @(negedge clk);
      got[0] = line[k];
      for (int j = 1; j < nb; j++) begin
        repeat (div) @(negedge clk);
        got[j] = line[k];
      end
      if (!mon_en[k]) continue;
      if (expq[k].size() == 0) begin
        chk("unexpected_frame", k, -1);
        continue;
      end
      b = expq[k].pop_front();
      req = '0;
      ones = 0;
      for (int i = 0; i < dw; i++) begin
        req[1 + i] = b[i];
        ones += int'(b[i]);
      end
      if (par == 1) req[1 + dw] = (ones % 2 == 0);
      if (par == 2) req[1 + dw] = (ones % 2 == 1);
      for (int j = 0; j < sb; j++) req[nb - 1 - j] = 1'b1;
      vecs++;
      if (got !== req) begin
        miss++;
        $display("FAIL frame dut%0d byte %02h: got line bits %b, expected %b",
                 k, b, got[11:0], req[11:0]);
      end
    end
  endtask

  initial begin
    int n;
    int nfd;
    int t_fall;
    int idlebad;
    rst0 = 1'b1;
    rstc = 1'b1;
    for (int i = 0; i < 5; i++) begin
      v[i] = 1'b0;
      d[i] = 8'h00;
      mon_en[i] = 1'b1;
    end
    fork
      monitor(0, 8, 0, 1, 10);
      monitor(1, 8, 2, 2, 10);
      monitor(2, 8, 1, 1, 10);
      monitor(3, 7, 1, 1, 10);
      monitor(4, 8, 0, 1, 1085);
    join_none

    repeat (3) @(negedge clk);
    rst0 = 1'b0;
    rstc = 1'b0;
    @(negedge clk);
    chk("reset_uart_tx", line[0], 1);
    chk("reset_tx_ready", rdy[0], 1);
    chk("reset_busy", bsy[0], 0);
    chk("reset_frame_done", fd[0], 0);
    chk("reset_level", lvl[0], 0);

    // Basic 8N1 and the parity / stop-bit variants
    send(0, 8'hA5); launch(0); frame_len(0, 99);
    send(1, 8'hA5); launch(1); frame_len(1, 119);
    send(2, 8'hA5); launch(2); frame_len(2, 109);
    send(3, 8'h41); launch(3); frame_len(3, 99);

    // FIFO fill with tx_valid held high, bytes 0x01..0x06
    send(0, 8'h01);
    chk("fill_level_first", lvl[0], 1);
    send(0, 8'h02);
    chk("simul_wr_pop_level1", lvl[0], 1);
    chk("fill_first_start_bit", line[0], 0);
    t_fall = cyc;
    send(0, 8'h03);
    send(0, 8'h04);
    send(0, 8'h05);
    chk("fill_level_full", lvl[0], 4);
    chk("fill_ready_low", rdy[0], 0);
    d[0] = 8'h06;
    n = 0;
    while (!fd[0] && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("full_level_at_frame_end", lvl[0], 4);
    @(negedge clk);
    chk("full_pop_refused_write", lvl[0], 3);
    chk("back_to_back_start", line[0], 0);
    send(0, 8'h06);
    v[0] = 1'b0;
    chk("refill_after_pop", lvl[0], 4);
    nfd = 0;
    n = 0;
    while (nfd < 5 && n < 1000) begin
      @(negedge clk);
      n++;
      if (fd[0]) nfd++;
    end
    chk("remaining_frames", nfd, 5);
    chk("six_frames_no_gap", cyc - t_fall, 599);
    repeat (3) @(negedge clk);

    // Reset during data bit 3 (0x35: bit 3 is 0) with two bytes queued
    mon_en[0] = 1'b0;
    send(0, 8'h35);
    send(0, 8'h5A);
    send(0, 8'h77);
    v[0] = 1'b0;
    repeat (44) @(negedge clk);
    chk("queued_before_reset", lvl[0], 2);
    chk("data_bit3_low", line[0], 0);
    #2 rst0 = 1'b1;
    #1;
    chk("async_reset_line_high", line[0], 1);
    chk("async_reset_level", lvl[0], 0);
    chk("async_reset_ready", rdy[0], 1);
    chk("async_reset_busy", bsy[0], 0);
    @(negedge clk);
    rst0 = 1'b0;
    expq[0].delete();
    idlebad = 0;
    repeat (300) begin
      @(negedge clk);
      if (line[0] !== 1'b1 || bsy[0] !== 1'b0) idlebad++;
    end
    chk("idle_after_reset", idlebad, 0);
    mon_en[0] = 1'b1;
    send(0, 8'h96); launch(0); frame_len(0, 99);

    // Divisor rounding: start bit width at 125 MHz / 115200
    send(4, 8'hA5); launch(4);
    n = 1;
    while (n < 3000) begin
      @(negedge clk);
      if (line[4] !== 1'b0) break;
      n++;
    end
    chk("bit_period_1085", n, 1085);
    n = 0;
    while (bsy[4] && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("u4_busy_clears", bsy[4], 0);
    repeat (20) @(negedge clk);

    for (int k = 0; k < 5; k++) chk("frames_outstanding", expq[k].size(), 0);
    chk("max_level", maxlvl0, 4);
    chk("ready_vs_level", rdybad0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
